fixed_divide_seq: RTL and testbench
===================================

# fixed_divide_seq

Iterative signed fixed-point divider with full valid/ready handshaking on both sides, divide-by-zero and overflow detection, and saturating output. Fraction width is an integer parameter. It sits in the Precision/Fixed library alongside the other fixed-point arithmetic blocks. It serves datapaths that need back-pressure and one divider shared over many cycles, rather than a free-running pipeline.

## Interface
- BITS, 8, total word width of operands and result (two's complement), BITS >= 2
- FRAC, 4, fraction bits in operands and result, 0 <= FRAC < BITS
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  divider can accept operands
- a  input  BITS  signed dividend, Q(BITS-FRAC).FRAC
- b  input  BITS  signed divisor, same format
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer takes result
- c  output  BITS  signed quotient, same format
- ovf  output  1  result saturated due to range overflow, qualified by out_valid
- dbz  output  1  divisor was zero, qualified by out_valid

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back operation.
- Accept occurs when in_valid && in_ready.
- On accept, the block registers:
  - sign = a[BITS-1]^b[BITS-1]
  - |a| and |b| as BITS-bit unsigned values, so -2^(BITS-1) is representable
  - dividend = |a| << FRAC, width BITS+FRAC
  - dbz = (b==0)
- If dbz: the next state is DONE directly. c = 0x7F..F if a > 0, 0x80..0 if a < 0, 0 if a == 0. ovf = 0.
- Otherwise the next state is CALC. CALC performs restoring division, 1 quotient bit per cycle, MSB first, for N iterations. N = BITS+FRAC, or BITS+FRAC+1 with rounding (see Configuration).
- Leaving CALC, the magnitude quotient q, of width BITS+FRAC, is compared against limits:
  - limit = 2^(BITS-1)-1 if sign = 0, 2^(BITS-1) if sign = 1
  - If q > limit: c saturates to the max/min code and ovf = 1.
  - Otherwise c = sign ? -q : q, truncated to BITS bits, and ovf = 0.
- Without rounding, truncation is toward zero.
- DONE: out_valid = 1. c, ovf and dbz are stable until out_ready.
  - If out_ready && !in_valid: go to IDLE.
  - If out_ready && in_valid: accept new operands in the same cycle.
- Negative zero cannot occur: q = 0 gives c = 0.
- Reset mid-CALC or mid-DONE aborts the operation. No result is produced.

## Timing
- Reset values: out_valid = 0, c = 0, ovf = 0, dbz = 0, state IDLE. in_ready reads 1 from reset.
- Accept at edge T: out_valid rises at edge T+N+1, or T+1 for dbz.
- The result stays valid for at least 1 cycle. It is held indefinitely while out_ready = 0.
- Peak throughput is one result per N+1 cycles with a continuous handshake.
- in_valid while busy is ignored. Upstream must hold operands until in_ready.
- Operands are sampled only at accept. Later changes to a and b have no effect.

## Configuration
- FIXED_DIVIDE_ROUND_EN defined:
  - One extra iteration produces a guard bit.
  - The magnitude is rounded half away from zero (q += guard) before the saturation check and sign application.
  - N = BITS+FRAC+1.
- Undefined: truncate toward zero, N = BITS+FRAC.

## Structure
- Shared package fixed_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE)
  - functions fixed_max(BITS) and fixed_min(BITS), returning the saturation codes
- One sub-module, fixed_div_step: combinational single restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - Instanced once and iterated by an iteration counter of width $clog2(N+1).

## Test plan
All cases use BITS=8, FRAC=4.
- a=0x18, b=0x08 (1.5/0.5) -> c=0x30, ovf=0, dbz=0. out_valid at accept+13 (accept+14 with ROUND_EN).
- a=0x20, b=0x30 (2/3) -> c=0x0A truncated, 0x0B with ROUND_EN. a=0xE0, b=0x30 -> c=0xF6, or 0xF5 with ROUND_EN.
- a=0x70, b=0x04 (7/0.25) -> c=0x7F, ovf=1. a=0x80, b=0xF0 (-8/-1) -> c=0x7F, ovf=1. a=0x80, b=0x10 -> c=0x80, ovf=0.
- a=0x10, b=0x00 -> c=0x7F, dbz=1, out_valid at accept+1. a=0xF0, b=0 -> c=0x80, dbz=1. a=0, b=0 -> c=0x00, dbz=1.
- Hold out_ready=0 for 5 cycles after out_valid: c stable, in_ready=0. Then out_ready=1 with in_valid=1: new operands accepted in the same cycle and the next result follows N+1 cycles later.
- Assert rstn=0 mid-CALC: out_valid=0 and c=0 immediately. After release, in_ready=1 and a fresh division completes correctly.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared definitions for the Precision/Fixed arithmetic blocks: divider FSM
// states and two's-complement saturation codes.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest positive code of a bits-wide word, zero-extended to 64 bits.
  function automatic logic [63:0] fixed_max(input int unsigned bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  // Most negative code of a bits-wide word, as an unsigned 64-bit value.
  function automatic logic [63:0] fixed_min(input int unsigned bits);
    return 64'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the quotient bit.
module fixed_div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvsr,
  input  logic         bit_in,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;

  // Trial subtraction on the shifted remainder; restore when it would go negative.
  always_comb begin
    trial    = {rem, bit_in};
    q_bit    = (trial >= {1'b0, dvsr});
    rem_next = q_bit ? W'(trial - {1'b0, dvsr}) : trial[W-1:0];
  end

endmodule

// File: rtl/fixed_divide_seq.sv
// Iterative signed fixed-point divider (Q(BITS-FRAC).FRAC) with valid/ready on
// both sides, divide-by-zero and overflow flags, and saturating result.
// Optional feature macro: FIXED_DIVIDE_ROUND_EN (round half away from zero).
module fixed_divide_seq #(
  parameter int unsigned BITS = 8,
  parameter int unsigned FRAC = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic            ovf,
  output logic            dbz
);

  import fixed_pkg::*;

  localparam int unsigned DW = BITS + FRAC;
`ifdef FIXED_DIVIDE_ROUND_EN
  localparam int unsigned N  = DW + 1;
`else
  localparam int unsigned N  = DW;
`endif
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned MW = DW + 1;

  localparam logic [BITS-1:0] C_MAX   = BITS'(fixed_max(BITS));
  localparam logic [BITS-1:0] C_MIN   = BITS'(fixed_min(BITS));
  localparam logic [MW-1:0]   LIM_POS = MW'(fixed_max(BITS));
  localparam logic [MW-1:0]   LIM_NEG = MW'(fixed_min(BITS));

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic              sign;
  logic [BITS-1:0]   dvsr;
  logic [BITS-1:0]   rem;
  logic [DW-1:0]     divd;
  logic [N-1:0]      quo;

  logic              accept;
  logic              b_zero;
  logic              last_iter;
  logic [BITS-1:0]   abs_a;
  logic [BITS-1:0]   abs_b;
  logic [BITS-1:0]   dbz_code;
  logic [BITS-1:0]   rem_step;
  logic              q_bit;
  logic [N-1:0]      q_fin;
  logic [MW-1:0]     mag;
  logic [MW-1:0]     mag_neg;
  logic [BITS-1:0]   res_c;
  logic              res_ovf;

  // Single restoring step, reused every CALC cycle.
  fixed_div_step #(.W(BITS)) u_step (
    .rem      (rem),
    .dvsr     (dvsr),
    .bit_in   (divd[DW-1]),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // Operand magnitudes and the divide-by-zero result code, taken at accept.
  always_comb begin
    b_zero   = (b == '0);
    abs_a    = a[BITS-1] ? (BITS'(~a) + BITS'(1)) : a;
    abs_b    = b[BITS-1] ? (BITS'(~b) + BITS'(1)) : b;
    dbz_code = (a == '0) ? '0 : (a[BITS-1] ? C_MIN : C_MAX);
  end

  // Final quotient magnitude, saturation check and sign application.
  always_comb begin
    last_iter = (cnt == CW'(N - 1));
    q_fin     = N'({quo, q_bit});
`ifdef FIXED_DIVIDE_ROUND_EN
    mag       = MW'(q_fin >> 1) + MW'(q_fin[0]);
`else
    mag       = MW'(q_fin);
`endif
    mag_neg   = MW'(0) - mag;
    res_ovf   = (mag > (sign ? LIM_NEG : LIM_POS));
    if (res_ovf) begin
      res_c = sign ? C_MIN : C_MAX;
    end else begin
      res_c = sign ? mag_neg[BITS-1:0] : mag[BITS-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, input handshake.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_next = b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        accept   = out_ready && in_valid;
        if (out_ready) begin
          if (in_valid) begin
            state_next = b_zero ? DONE : CALC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load at accept, iterate in CALC, publish and hold the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      sign      <= 1'b0;
      dvsr      <= '0;
      rem       <= '0;
      divd      <= '0;
      quo       <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      sign <= a[BITS-1] ^ b[BITS-1];
      dvsr <= abs_b;
      rem  <= '0;
      divd <= DW'(abs_a) << FRAC;
      quo  <= '0;
      if (b_zero) begin
        c         <= dbz_code;
        ovf       <= 1'b0;
        dbz       <= 1'b1;
        out_valid <= 1'b1;
      end else begin
        dbz       <= 1'b0;
        out_valid <= 1'b0;
      end
    end else if (state == CALC) begin
      rem  <= rem_step;
      divd <= divd << 1;
      quo  <= q_fin;
      cnt  <= cnt + CW'(1);
      if (last_iter) begin
        c         <= res_c;
        ovf       <= res_ovf;
        dbz       <= 1'b0;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Self-checking bench for fixed_divide_seq (BITS=8, FRAC=4): directed cases,
// back-pressure, back-to-back handshake, mid-operation reset, random operands.
module tb_fixed_divide_seq;

  localparam int BITS = 8;
  localparam int FRAC = 4;
`ifdef FIXED_DIVIDE_ROUND_EN
  localparam int N = BITS + FRAC + 1;
  localparam bit ROUND = 1'b1;
`else
  localparam int N = BITS + FRAC;
  localparam bit ROUND = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] c;
  logic            ovf;
  logic            dbz;

  int tests_run;
  int tests_failed;

  logic [BITS-1:0] cur_a;
  logic [BITS-1:0] cur_b;

  fixed_divide_seq #(.BITS(BITS), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (a=0x%0h b=0x%0h)", tag, obs, exp, cur_a, cur_b);
    end
  endtask

  // Reference: exact rational quotient in integers, then saturate and sign.
  task automatic model(input logic [BITS-1:0] ia, input logic [BITS-1:0] ib,
                       output int ec, output int eo, output int ed);
    int sa, sb, ma, mb, num, q, lim, v;
    bit neg;
    logic [BITS-1:0] tmp;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ed = 0;
    eo = 0;
    if (sb == 0) begin
      ed = 1;
      ec = (sa > 0) ? (2**(BITS-1) - 1) : ((sa < 0) ? 2**(BITS-1) : 0);
    end else begin
      neg = (sa < 0) != (sb < 0);
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      num = ma * (2**FRAC);
      q   = ROUND ? (2 * num + mb) / (2 * mb) : num / mb;
      lim = neg ? 2**(BITS-1) : 2**(BITS-1) - 1;
      if (q > lim) begin
        eo = 1;
        ec = neg ? 2**(BITS-1) : 2**(BITS-1) - 1;
      end else begin
        v   = neg ? -q : q;
        tmp = v[BITS-1:0];
        ec  = int'(tmp);
      end
    end
  endtask

  // Present operands and complete the input handshake.
  task automatic start_op(input logic [BITS-1:0] ia, input logic [BITS-1:0] ib);
    int k;
    cur_a    = ia;
    cur_b    = ib;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = BITS'($urandom);
    b = BITS'($urandom);
  endtask

  // Wait for the result, then check latency and payload.
  task automatic wait_result(output int ec);
    int k, eo, ed;
    model(cur_a, cur_b, ec, eo, ed);
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, ed ? 1 : N + 1);
    check("c", int'(c), ec);
    check("ovf", int'(ovf), eo);
    check("dbz", int'(dbz), ed);
  endtask

  task automatic run_op(input logic [BITS-1:0] ia, input logic [BITS-1:0] ib, input int hold);
    int ec;
    out_ready = (hold == 0);
    start_op(ia, ib);
    wait_result(ec);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_c", int'(c), ec);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("taken_valid", int'(out_valid), 0);
    check("taken_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int ec;
    logic [BITS-1:0] ra, rb;
    clk          = 1'b0;
    rstn         = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    a            = '0;
    b            = '0;
    cur_a        = '0;
    cur_b        = '0;
    tests_run    = 0;
    tests_failed = 0;

    repeat (3) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_c", int'(c), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dbz", int'(dbz), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(8'h18, 8'h08, 0);
    run_op(8'h20, 8'h30, 0);
    run_op(8'hE0, 8'h30, 0);
    run_op(8'h70, 8'h04, 0);
    run_op(8'h80, 8'hF0, 0);
    run_op(8'h80, 8'h10, 0);
    run_op(8'h10, 8'h00, 0);
    run_op(8'hF0, 8'h00, 0);
    run_op(8'h00, 8'h00, 0);
    run_op(8'h00, 8'hF0, 1);

    // Back-pressure then back-to-back accept in the releasing cycle
    out_ready = 1'b0;
    start_op(8'h18, 8'h08);
    wait_result(ec);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_hold_c", int'(c), ec);
      check("b2b_hold_in_ready", int'(in_ready), 0);
    end
    cur_a     = 8'h20;
    cur_b     = 8'h30;
    a         = cur_a;
    b         = cur_b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h55;
    b = 8'h01;
    check("b2b_valid_drop", int'(out_valid), 0);
    wait_result(ec);
    @(posedge clk);
    @(negedge clk);

    // Reset during CALC aborts the operation
    out_ready = 1'b1;
    start_op(8'h70, 8'h30);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_c", int'(c), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_idle_valid", int'(out_valid), 0);
    run_op(8'hE0, 8'h30, 0);

    // Random operands with occasional zero divisor and back-pressure
    for (int i = 0; i < 150; i++) begin
      ra = BITS'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : BITS'($urandom);
      run_op(ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
